// File: rtl/line_track_pkg.sv
// Shared definitions for the line-track indicator: FSM encoding, 7-seg glyphs,
// hex decoder and 16-bit signed saturation.
package line_track_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_COAST = 2'b10,
    ST_LOST  = 2'b11
  } track_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    logic signed [15:0] r;
    if (v > 18'sd32767)
      r = 16'sh7FFF;
    else if (v < -18'sd32768)
      r = 16'sh8000;
    else
      r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/led_bar_encoder.sv
// Converts an error magnitude and sign into a thermometer LED bar on the
// matching side, or the centre LED when inside the deadband.
module led_bar_encoder #(
  parameter int LED_N     = 9,
  parameter int DEADBAND  = 4,
  parameter int LED_SHIFT = 2
) (
  input  logic [15:0]      mag,
  input  logic             sign,
  input  logic             enable,
  output logic [LED_N-1:0] led_left,
  output logic [LED_N-1:0] led_right,
  output logic             led_center
);

  logic             above;
  logic [15:0]      steps;
  logic [15:0]      n_lit;
  logic [LED_N-1:0] therm;

  // steps is only meaningful when above the deadband; the wrap below it is unused
  always_comb begin
    above = mag > 16'(DEADBAND);
    steps = ((mag - 16'(DEADBAND) - 16'd1) >> LED_SHIFT) + 16'd1;
    n_lit = (steps > 16'(LED_N)) ? 16'(LED_N) : steps;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LED_N; gi++) begin : g_therm
      assign therm[gi] = 16'(gi) < n_lit;
    end
  endgenerate

  always_comb begin
    led_left   = '0;
    led_right  = '0;
    led_center = 1'b0;
    if (enable) begin
      if (!above)
        led_center = 1'b1;
      else if (sign)
        led_left = therm;
      else
        led_right = therm;
    end
  end

endmodule

// File: rtl/line_track_indicator.sv
// Three-stage line-follow indicator: steering error, moving-average filter with
// coast/lost tracking, then registered LED bar and 7-seg outputs.
module line_track_indicator
  import line_track_pkg::*;
#(
  parameter int MAX_W       = 640,
  parameter int AVG_LOG2    = 2,
  parameter int LED_N       = 9,
  parameter int DEADBAND    = 4,
  parameter int LED_SHIFT   = 2,
  parameter int LOST_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_valid,
  input  logic [15:0]        frame_width,
  input  logic [15:0]        frame_cx,
  input  logic               frame_detected,
  output logic signed [15:0] error_filt,
  output logic [1:0]         state,
  output logic [LED_N-1:0]   led_left,
  output logic [LED_N-1:0]   led_right,
  output logic               led_center,
  output logic               lost_alarm,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 16 + AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PTR_W-1:0] PTR_INIT = (AVG_LOG2 == 0) ? '0 : PTR_W'(1);

  // ---------------- stage 1: raw error ----------------
  logic [15:0]        w_eff;
  logic [15:0]        half_w;
  logic signed [17:0] raw_wide;

  always_comb begin
    w_eff    = (frame_width == 16'd0) ? 16'(MAX_W) : frame_width;
    half_w   = w_eff >> 1;
    raw_wide = $signed({2'b00, frame_cx}) - $signed({2'b00, half_w});
  end

  logic               s1_valid_reg;
  logic               s1_det_reg;
  logic signed [15:0] s1_raw_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_det_reg   <= 1'b0;
      s1_raw_reg   <= '0;
    end else begin
      s1_valid_reg <= frame_valid;
      s1_det_reg   <= frame_valid & frame_detected;
      if (frame_valid)
        s1_raw_reg <= sat16(raw_wide);
    end
  end

  // ---------------- stage 2: FSM and moving average ----------------
  track_state_e             state_reg;
  logic signed [SUM_W-1:0]  sum_reg;
  logic [PTR_W-1:0]         ptr_reg;
  logic [7:0]               miss_cnt_reg;
  logic signed [15:0]       hist_reg [DEPTH];

  logic                     prime_c;
  logic                     update_c;
  logic [PTR_W-1:0]         ptr_next_c;
  logic signed [SUM_W-1:0]  raw_ext_c;
  logic signed [SUM_W-1:0]  sum_upd_c;

  always_comb begin
    prime_c    = s1_valid_reg & s1_det_reg &
                 ((state_reg == ST_IDLE) | (state_reg == ST_LOST));
    update_c   = s1_valid_reg & s1_det_reg &
                 ((state_reg == ST_TRACK) | (state_reg == ST_COAST));
    ptr_next_c = (AVG_LOG2 == 0) ? '0 : ptr_reg + PTR_W'(1);
    raw_ext_c  = SUM_W'(s1_raw_reg);
    sum_upd_c  = sum_reg + raw_ext_c - SUM_W'(hist_reg[ptr_reg]);
  end

  // Priming fills the whole window so the average starts at the first sample
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset_n)
        hist_reg[i] <= '0;
      else if (prime_c || (update_c && ptr_reg == PTR_W'(i)))
        hist_reg[i] <= s1_raw_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      sum_reg      <= '0;
      ptr_reg      <= '0;
      miss_cnt_reg <= '0;
    end else if (s1_valid_reg) begin
      case (state_reg)
        ST_IDLE, ST_LOST: begin
          if (s1_det_reg) begin
            state_reg    <= ST_TRACK;
            sum_reg      <= raw_ext_c <<< AVG_LOG2;
            ptr_reg      <= PTR_INIT;
            miss_cnt_reg <= '0;
          end
        end
        ST_TRACK: begin
          if (s1_det_reg) begin
            sum_reg <= sum_upd_c;
            ptr_reg <= ptr_next_c;
          end else begin
            state_reg    <= ST_COAST;
            miss_cnt_reg <= 8'd1;
          end
        end
        ST_COAST: begin
          if (s1_det_reg) begin
            state_reg    <= ST_TRACK;
            sum_reg      <= sum_upd_c;
            ptr_reg      <= ptr_next_c;
            miss_cnt_reg <= '0;
          end else if (miss_cnt_reg + 8'd1 == 8'(LOST_FRAMES)) begin
            state_reg    <= ST_LOST;
            miss_cnt_reg <= '0;
          end else begin
            miss_cnt_reg <= miss_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // ---------------- stage 3: display outputs ----------------
  logic signed [15:0] avg_c;
  logic [15:0]        mag_c;
  logic               active_c;
  logic [11:0]        digits_c;
  logic [LED_N-1:0]   bar_left_c;
  logic [LED_N-1:0]   bar_right_c;
  logic               center_c;

  always_comb begin
    avg_c    = 16'(sum_reg >>> AVG_LOG2);
    mag_c    = (avg_c == 16'sh8000) ? 16'd32767 :
               (avg_c < 0) ? 16'(-avg_c) : 16'(avg_c);
    active_c = (state_reg == ST_TRACK) | (state_reg == ST_COAST);
    digits_c = (mag_c > 16'h0FFF) ? 12'hFFF : mag_c[11:0];
  end

  led_bar_encoder #(
    .LED_N     (LED_N),
    .DEADBAND  (DEADBAND),
    .LED_SHIFT (LED_SHIFT)
  ) u_led_bar (
    .mag        (mag_c),
    .sign       (avg_c[15]),
    .enable     (active_c),
    .led_left   (bar_left_c),
    .led_right  (bar_right_c),
    .led_center (center_c)
  );

  logic signed [15:0] error_filt_reg;
  logic [1:0]         state_out_reg;
  logic [LED_N-1:0]   led_left_reg;
  logic [LED_N-1:0]   led_right_reg;
  logic               led_center_reg;
  logic               lost_alarm_reg;
  logic [6:0]         hex0_reg, hex1_reg, hex2_reg, hex3_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error_filt_reg <= '0;
      state_out_reg  <= ST_IDLE;
      led_left_reg   <= '0;
      led_right_reg  <= '0;
      led_center_reg <= 1'b0;
      lost_alarm_reg <= 1'b0;
      hex0_reg       <= SEG_BLANK;
      hex1_reg       <= SEG_BLANK;
      hex2_reg       <= SEG_BLANK;
      hex3_reg       <= SEG_BLANK;
    end else begin
      error_filt_reg <= active_c ? avg_c : 16'sd0;
      state_out_reg  <= state_reg;
      led_left_reg   <= bar_left_c;
      led_right_reg  <= bar_right_c;
      led_center_reg <= center_c;
      lost_alarm_reg <= (state_reg == ST_LOST);
      case (state_reg)
        ST_IDLE: begin
          hex0_reg <= SEG_BLANK;
          hex1_reg <= SEG_BLANK;
          hex2_reg <= SEG_BLANK;
          hex3_reg <= SEG_BLANK;
        end
        ST_LOST: begin
          hex0_reg <= SEG_DASH;
          hex1_reg <= SEG_DASH;
          hex2_reg <= SEG_DASH;
          hex3_reg <= SEG_DASH;
        end
        default: begin
          hex0_reg <= hex_to_seg(digits_c[3:0]);
          hex1_reg <= hex_to_seg(digits_c[7:4]);
          hex2_reg <= hex_to_seg(digits_c[11:8]);
          hex3_reg <= avg_c[15] ? SEG_DASH : SEG_BLANK;
        end
      endcase
    end
  end

  assign error_filt = error_filt_reg;
  assign state      = state_out_reg;
  assign led_left   = led_left_reg;
  assign led_right  = led_right_reg;
  assign led_center = led_center_reg;
  assign lost_alarm = lost_alarm_reg;
  assign HEX0       = hex0_reg;
  assign HEX1       = hex1_reg;
  assign HEX2       = hex2_reg;
  assign HEX3       = hex3_reg;

endmodule

// File: tb/tb_line_track_indicator.sv
// Self-checking bench for line_track_indicator: directed scenarios plus a
// randomized stream checked against a queue-based moving-average model.
module tb_line_track_indicator;

  localparam int DEPTH = 4;
  localparam int DB    = 4;
  localparam int LSH   = 2;
  localparam int LN    = 9;
  localparam int LOSTN = 8;

  localparam logic [65:0] RESET_VEC =
    {16'h0, 2'b00, 9'h0, 9'h0, 1'b0, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               frame_valid = 1'b0;
  logic [15:0]        frame_width = '0;
  logic [15:0]        frame_cx = '0;
  logic               frame_detected = 1'b0;
  logic signed [15:0] error_filt;
  logic [1:0]         state;
  logic [8:0]         led_left;
  logic [8:0]         led_right;
  logic               led_center;
  logic               lost_alarm;
  logic [6:0]         HEX0, HEX1, HEX2, HEX3;

  int checks = 0;
  int errors = 0;

  // model: 0 IDLE, 1 TRACK, 2 COAST, 3 LOST; window holds the last DEPTH raws
  int m_state;
  int m_win[$];
  int m_miss;

  line_track_indicator dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_valid    (frame_valid),
    .frame_width    (frame_width),
    .frame_cx       (frame_cx),
    .frame_detected (frame_detected),
    .error_filt     (error_filt),
    .state          (state),
    .led_left       (led_left),
    .led_right      (led_right),
    .led_center     (led_center),
    .lost_alarm     (lost_alarm),
    .HEX0           (HEX0),
    .HEX1           (HEX1),
    .HEX2           (HEX2),
    .HEX3           (HEX3)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
      12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic int model_raw(input int w, input int cx);
    int we;
    int r;
    we = (w == 0) ? 640 : w;
    r  = cx - we / 2;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_win.delete();
    m_miss = 0;
  endfunction

  function automatic void model_frame(input int w, input int cx, input bit det);
    int r;
    r = model_raw(w, cx);
    case (m_state)
      0, 3: if (det) begin
        m_win.delete();
        for (int i = 0; i < DEPTH; i++) m_win.push_back(r);
        m_state = 1;
        m_miss  = 0;
      end
      1: if (det) begin
        m_win.push_back(r);
        void'(m_win.pop_front());
      end else begin
        m_state = 2;
        m_miss  = 1;
      end
      default: if (det) begin
        m_win.push_back(r);
        void'(m_win.pop_front());
        m_state = 1;
        m_miss  = 0;
      end else begin
        m_miss++;
        if (m_miss == LOSTN) begin
          m_state = 3;
          m_miss  = 0;
        end
      end
    endcase
  endfunction

  function automatic int model_avg();
    int s;
    s = 0;
    foreach (m_win[i]) s += m_win[i];
    if (s >= 0) return s / DEPTH;
    return -((-s + DEPTH - 1) / DEPTH);
  endfunction

  function automatic logic [65:0] model_vec();
    int avg, mag, n, d;
    bit active;
    logic [15:0] err;
    logic [8:0] ll, lr;
    logic lc;
    logic [6:0] h0, h1, h2, h3;
    active = (m_state == 1) || (m_state == 2);
    avg = active ? model_avg() : 0;
    mag = (avg == -32768) ? 32767 : ((avg < 0) ? -avg : avg);
    ll = '0; lr = '0; lc = 1'b0;
    if (active) begin
      if (mag <= DB) lc = 1'b1;
      else begin
        n = (mag - DB - 1) / (1 << LSH) + 1;
        if (n > LN) n = LN;
        if (avg < 0) ll = 9'((1 << n) - 1);
        else lr = 9'((1 << n) - 1);
      end
    end
    err = active ? 16'(avg) : 16'h0;
    if (m_state == 0) begin
      h0 = 7'h7F; h1 = 7'h7F; h2 = 7'h7F; h3 = 7'h7F;
    end else if (m_state == 3) begin
      h0 = 7'h3F; h1 = 7'h3F; h2 = 7'h3F; h3 = 7'h3F;
    end else begin
      d  = (mag > 4095) ? 4095 : mag;
      h0 = seg(d % 16);
      h1 = seg((d / 16) % 16);
      h2 = seg(d / 256);
      h3 = (avg < 0) ? 7'h3F : 7'h7F;
    end
    return {err, 2'(m_state), ll, lr, lc, (m_state == 3) ? 1'b1 : 1'b0, h3, h2, h1, h0};
  endfunction

  function automatic logic [65:0] dut_vec();
    return {error_filt, state, led_left, led_right, led_center, lost_alarm,
            HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic apply_reset();
    reset_n     = 1'b0;
    frame_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Drives one frame, scrambles inputs while idle, and returns after the outputs settle.
  task automatic send(input int w, input int cx, input bit det);
    frame_width    = 16'(w);
    frame_cx       = 16'(cx);
    frame_detected = det;
    frame_valid    = 1'b1;
    @(posedge clk);
    #1;
    frame_valid    = 1'b0;
    frame_width    = 16'($urandom);
    frame_cx       = 16'($urandom);
    frame_detected = 1'($urandom);
    model_frame(w, cx, det);
    repeat (2) @(posedge clk);
    #1;
    $display("frame w=%0d cx=%0d det=%0d -> err=%0d state=%0d", w, cx, det, error_filt, state);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values got %h want %h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_prime();
    send(0, 330, 1'b1);
    checks++;
    if ({error_filt, state, led_right, HEX0, HEX3} !==
        {16'sd10, 2'b01, 9'b000000011, 7'h08, 7'h7F}) begin
      errors++;
      $display("FAIL prime_direct got err=%0d st=%0d lr=%b h0=%h h3=%h",
               error_filt, state, led_right, HEX0, HEX3);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL prime_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_negative();
    apply_reset();
    send(640, 320, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      send(640, 280, 1'b1);
      checks++;
      if (error_filt !== 16'(-10 * i)) begin
        errors++;
        $display("FAIL neg_step%0d got %0d want %0d", i, error_filt, -10 * i);
      end
    end
    checks++;
    if ({led_left, led_right, HEX3, HEX1, HEX0} !== {9'h1FF, 9'h0, 7'h3F, 7'h24, 7'h00}) begin
      errors++;
      $display("FAIL neg_display got ll=%b lr=%b h3=%h h1=%h h0=%h",
               led_left, led_right, HEX3, HEX1, HEX0);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL neg_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_coast();
    send(640, 320, 1'b0);
    checks++;
    if ({state, error_filt} !== {2'b10, -16'sd40}) begin
      errors++;
      $display("FAIL coast_hold got st=%0d err=%0d want st=2 err=-40", state, error_filt);
    end
    send(640, 400, 1'b1);
    checks++;
    if ({state, error_filt} !== {2'b01, -16'sd10}) begin
      errors++;
      $display("FAIL coast_resume got st=%0d err=%0d want st=1 err=-10", state, error_filt);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL coast_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_lost();
    send(640, 320, 1'b1);
    for (int i = 1; i <= LOSTN; i++) begin
      send(640, 0, 1'b0);
      checks++;
      if (i < LOSTN && {state, lost_alarm} !== {2'b10, 1'b0}) begin
        errors++;
        $display("FAIL lost_coast%0d got st=%0d alarm=%0d", i, state, lost_alarm);
      end else if (i == LOSTN &&
                   {state, lost_alarm, error_filt, HEX3, HEX2, HEX1, HEX0} !==
                   {2'b11, 1'b1, 16'h0, 7'h3F, 7'h3F, 7'h3F, 7'h3F}) begin
        errors++;
        $display("FAIL lost_enter got st=%0d alarm=%0d err=%0d hex=%h%h%h%h",
                 state, lost_alarm, error_filt, HEX3, HEX2, HEX1, HEX0);
      end
    end
    send(640, 420, 1'b1);
    checks++;
    if ({state, error_filt, lost_alarm} !== {2'b01, 16'sd100, 1'b0}) begin
      errors++;
      $display("FAIL lost_reprime got st=%0d err=%0d alarm=%0d", state, error_filt, lost_alarm);
    end
  endtask

  task automatic test_deadband_sat();
    apply_reset();
    send(640, 323, 1'b1);
    checks++;
    if ({led_center, led_left, led_right, error_filt} !== {1'b1, 9'h0, 9'h0, 16'sd3}) begin
      errors++;
      $display("FAIL deadband got lc=%0d ll=%b lr=%b err=%0d", led_center, led_left, led_right, error_filt);
    end
    apply_reset();
    send(640, 65535, 1'b1);
    checks++;
    if ({error_filt, HEX2, HEX1, HEX0, led_right} !== {16'sh7FFF, 7'h0E, 7'h0E, 7'h0E, 9'h1FF}) begin
      errors++;
      $display("FAIL saturate got err=%0d hex=%h%h%h lr=%b", error_filt, HEX2, HEX1, HEX0, led_right);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    send(640, 340, 1'b1);
    frame_width    = 16'd640;
    frame_cx       = 16'd600;
    frame_detected = 1'b1;
    frame_valid    = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    reset_n     = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL midreset_now got %h want %h", dut_vec(), RESET_VEC);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL midreset_dropped got %h want %h", dut_vec(), model_vec());
    end
  endtask

  // Random frames, possibly every cycle, with idle gaps carrying garbage inputs.
  task automatic test_back_to_back();
    localparam int N = 80;
    logic [65:0] exp_q[$];
    int w, cx;
    bit v, det;
    apply_reset();
    for (int k = 0; k < N + 2; k++) begin
      v = 1'b0; w = 0; cx = 0; det = 1'b0;
      if (k < N) begin
        v   = $urandom_range(0, 9) < 8;
        det = $urandom_range(0, 99) < ((k < N / 2) ? 80 : 12);
        case ($urandom_range(0, 3))
          0: w = 0;
          1: w = 640;
          2: w = 320;
          default: w = $urandom_range(1, 2000);
        endcase
        cx = ($urandom_range(0, 9) == 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 1400);
        frame_width    = 16'(w);
        frame_cx       = 16'(cx);
        frame_detected = det;
      end
      frame_valid = v;
      @(posedge clk);
      #1;
      if (v) model_frame(w, cx, det);
      exp_q.push_back(model_vec());
      if (k >= 2) begin
        checks++;
        if (dut_vec() !== exp_q[k - 2]) begin
          errors++;
          $display("FAIL b2b_cycle%0d got %h want %h", k, dut_vec(), exp_q[k - 2]);
        end
        $display("cycle %0d valid=%0d w=%0d cx=%0d det=%0d -> err=%0d state=%0d",
                 k, v, w, cx, det, error_filt, state);
      end
    end
    frame_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prime();
    test_negative();
    test_coast();
    test_lost();
    test_deadband_sat();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
